// File: rtl/sm_move_seq_if.sv
// Command, configuration and status bundle for the move sequencer.
// master: the controller side (drives commands, config and pulse_tick; observes status).
// slave : the sequencer side (consumes commands/config/ticks; drives period, enable and status).
interface sm_move_seq_if #(
    parameter int unsigned SIZE = 16
);
    logic            cmd_start;
    logic            cmd_stop;
    logic            cmd_abort;
    logic            cmd_dir;
    logic [SIZE-1:0] cmd_steps;
    logic [SIZE-1:0] cfg_period_start;
    logic [SIZE-1:0] cfg_period_min;
    logic [SIZE-1:0] cfg_ramp_dec;
    logic            pulse_tick;
    logic [SIZE-1:0] period;
    logic            drv_en_SM;
    logic            dir;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] remaining;

    modport master (
        output cmd_start, cmd_stop, cmd_abort, cmd_dir, cmd_steps,
        output cfg_period_start, cfg_period_min, cfg_ramp_dec, pulse_tick,
        input  period, drv_en_SM, dir, busy, done, remaining
    );

    modport slave (
        input  cmd_start, cmd_stop, cmd_abort, cmd_dir, cmd_steps,
        input  cfg_period_start, cfg_period_min, cfg_ramp_dec, pulse_tick,
        output period, drv_en_SM, dir, busy, done, remaining
    );
endinterface

// File: rtl/sm_move_seq.sv
// Stepper move sequencer: trapezoidal period profile (accelerate, cruise, decelerate) driven
// by pulse_tick strobes from an external pulse generator.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset, release synchronised internally
//   bus_io - sm_move_seq_if.slave: commands/config/pulse_tick in; period, drv_en_SM, dir,
//            busy, done, remaining out (all registered)
module sm_move_seq #(
    parameter int unsigned SIZE     = 16,
    parameter int unsigned RAMP_MAX = 1024
) (
    input logic          clk,
    input logic          rst_n,
    sm_move_seq_if.slave bus_io
);

    localparam int unsigned      RampW   = $clog2(RAMP_MAX + 1);
    localparam logic [RampW-1:0] RampSat = RampW'(RAMP_MAX);

    typedef enum logic [2:0] {StIdle, StAccel, StCruise, StDecel, StDone} state_e;

    state_e           state_q, state_d;
    logic [SIZE-1:0]  period_q, period_d;
    logic [SIZE-1:0]  rem_q, rem_d;
    logic [RampW-1:0] ramp_q, ramp_d;
    logic             dir_q, dir_d;
    logic             busy_q, drv_en_q, done_q;
    logic             rst_sync_q;

    // Helper values shared by the next-state logic
    logic [SIZE-1:0]  rem_tick;    // remaining after one tick, floored at 0
    logic [SIZE-1:0]  rem_now;     // remaining including a coincident tick
    logic [SIZE-1:0]  rem_stop;    // min(rem_now, ramp_q)
    logic [SIZE-1:0]  period_diff;
    logic [SIZE-1:0]  period_acc;  // accelerated period, clamped at cfg_period_min
    logic [SIZE:0]    period_sum;
    logic [SIZE-1:0]  period_dec;  // decelerated period, clamped at cfg_period_start
    logic [RampW-1:0] ramp_inc;
    logic [RampW-1:0] ramp_dn;
    logic [RampW-1:0] ramp_nxt;

    always_comb begin
        rem_tick = (rem_q == '0) ? '0 : rem_q - SIZE'(1);
        rem_now  = bus_io.pulse_tick ? rem_tick : rem_q;
        // In the else branch ramp_q < rem_now, so it fits in SIZE bits
        if (32'(rem_now) <= 32'(ramp_q)) begin
            rem_stop = rem_now;
        end else begin
            rem_stop = SIZE'(ramp_q);
        end

        period_diff = period_q - bus_io.cfg_ramp_dec;
        if ((bus_io.cfg_ramp_dec > period_q) || (period_diff < bus_io.cfg_period_min)) begin
            period_acc = bus_io.cfg_period_min;
        end else begin
            period_acc = period_diff;
        end

        // Extra MSB catches the carry so an overflowing sum saturates too
        period_sum = {1'b0, period_q} + {1'b0, bus_io.cfg_ramp_dec};
        if (period_sum > {1'b0, bus_io.cfg_period_start}) begin
            period_dec = bus_io.cfg_period_start;
        end else begin
            period_dec = period_sum[SIZE-1:0];
        end

        ramp_inc = (ramp_q >= RampSat) ? RampSat : ramp_q + RampW'(1);
        ramp_dn  = (ramp_q == '0) ? '0 : ramp_q - RampW'(1);
        ramp_nxt = (state_q == StAccel) ? ramp_inc : ramp_q;
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        rem_d    = rem_q;
        ramp_d   = ramp_q;
        dir_d    = dir_q;

        if ((state_q != StIdle) && bus_io.cmd_abort) begin
            state_d  = StIdle;
            period_d = bus_io.cfg_period_start;
            rem_d    = '0;
            ramp_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.cmd_start) begin
                        dir_d    = bus_io.cmd_dir;
                        rem_d    = bus_io.cmd_steps;
                        period_d = bus_io.cfg_period_start;
                        ramp_d   = '0;
                        state_d  = (bus_io.cmd_steps == '0) ? StDone : StAccel;
                    end
                end
                StAccel, StCruise: begin
                    if (bus_io.cmd_stop) begin
                        // Ramp down over as many pulses as were spent ramping up
                        rem_d   = rem_stop;
                        state_d = (rem_stop == '0) ? StDone : StDecel;
                    end else if (bus_io.pulse_tick) begin
                        rem_d  = rem_tick;
                        ramp_d = ramp_nxt;
                        if (state_q == StAccel) begin
                            period_d = period_acc;
                        end
                        if (rem_tick == '0) begin
                            state_d = StDone;
                        end else if (32'(rem_tick) <= 32'(ramp_nxt)) begin
                            state_d = StDecel;
                        end else if ((state_q == StAccel) &&
                                     (period_acc == bus_io.cfg_period_min)) begin
                            state_d = StCruise;
                        end
                    end
                end
                StDecel: begin
                    if (bus_io.pulse_tick) begin
                        rem_d    = rem_tick;
                        period_d = period_dec;
                        ramp_d   = ramp_dn;
                        if (rem_tick == '0) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Single-stage release synchroniser: state first updates on the second edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            period_q <= '0;
            rem_q    <= '0;
            ramp_q   <= '0;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            drv_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (rst_sync_q) begin
            state_q  <= state_d;
            period_q <= period_d;
            rem_q    <= rem_d;
            ramp_q   <= ramp_d;
            dir_q    <= dir_d;
            busy_q   <= (state_d != StIdle);
            drv_en_q <= (state_d == StAccel) || (state_d == StCruise) || (state_d == StDecel);
            done_q   <= (state_d == StDone);
        end
    end

    assign bus_io.period    = period_q;
    assign bus_io.remaining = rem_q;
    assign bus_io.dir       = dir_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.drv_en_SM = drv_en_q;
    assign bus_io.done      = done_q;

endmodule

// File: tb/tb_sm_move_seq.sv
// Self-checking bench for sm_move_seq: a behavioural model pushes the expected registered
// outputs for each driven cycle onto a scoreboard queue, popped and compared after the edge.
module tb_sm_move_seq;

    localparam int SIdle = 0, SAccel = 1, SCruise = 2, SDecel = 3, SDone = 4;
    localparam int RampMax = 1024;

    typedef struct {
        int period;
        int rem;
        bit busy;
        bit drv;
        bit done;
        bit dir;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    sm_move_seq_if #(.SIZE(16)) bus ();

    sm_move_seq #(
        .SIZE     (16),
        .RAMP_MAX (RampMax)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #10 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    string cur_test = "init";
    exp_t  sb_q[$];

    // Model state
    int ms, m_period, m_rem, m_ramp, m_hold;
    bit m_dir;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", cur_test, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ms = SIdle; m_period = 0; m_rem = 0; m_ramp = 0; m_dir = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit ab, input bit tk);
        int pstart, pmin, dec;
        if (m_hold > 0) begin
            m_hold--;
            return;
        end
        pstart = int'(bus.cfg_period_start);
        pmin   = int'(bus.cfg_period_min);
        dec    = int'(bus.cfg_ramp_dec);
        if (ms != SIdle && ab) begin
            ms = SIdle; m_period = pstart; m_rem = 0; m_ramp = 0;
        end else begin
            case (ms)
                SIdle: if (st) begin
                    m_dir = bus.cmd_dir; m_rem = int'(bus.cmd_steps);
                    m_period = pstart; m_ramp = 0;
                    ms = (m_rem == 0) ? SDone : SAccel;
                end
                SAccel, SCruise: begin
                    if (sp) begin
                        if (tk && m_rem > 0) m_rem--;
                        if (m_ramp < m_rem) m_rem = m_ramp;
                        ms = (m_rem == 0) ? SDone : SDecel;
                    end else if (tk) begin
                        if (m_rem > 0) m_rem--;
                        if (ms == SAccel) begin
                            m_period = (dec > m_period || m_period - dec < pmin) ? pmin
                                                                                : m_period - dec;
                            if (m_ramp < RampMax) m_ramp++;
                        end
                        if (m_rem == 0) ms = SDone;
                        else if (m_rem <= m_ramp) ms = SDecel;
                        else if (ms == SAccel && m_period == pmin) ms = SCruise;
                    end
                end
                SDecel: if (tk) begin
                    if (m_rem > 0) m_rem--;
                    m_period = (m_period + dec > pstart) ? pstart : m_period + dec;
                    if (m_ramp > 0) m_ramp--;
                    if (m_rem == 0) ms = SDone;
                end
                SDone: ms = SIdle;
                default: ms = SIdle;
            endcase
        end
    endtask

    // One clock: drive strobes, predict, compare after the edge, clear strobes on negedge
    task automatic cycle(input bit st, input bit sp, input bit ab, input bit tk);
        exp_t e;
        bus.cmd_start  = st;
        bus.cmd_stop   = sp;
        bus.cmd_abort  = ab;
        bus.pulse_tick = tk;
        model_step(st, sp, ab, tk);
        e.period = m_period;
        e.rem    = m_rem;
        e.busy   = (ms != SIdle);
        e.drv    = (ms == SAccel || ms == SCruise || ms == SDecel);
        e.done   = (ms == SDone);
        e.dir    = m_dir;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("period", 32'(bus.period), e.period);
            check_eq("remaining", 32'(bus.remaining), e.rem);
            check_eq("busy", 32'(bus.busy), 32'(e.busy));
            check_eq("drv_en_SM", 32'(bus.drv_en_SM), 32'(e.drv));
            check_eq("done", 32'(bus.done), 32'(e.done));
            check_eq("dir", 32'(bus.dir), 32'(e.dir));
        end
        @(negedge clk);
        bus.cmd_start  = 1'b0;
        bus.cmd_stop   = 1'b0;
        bus.cmd_abort  = 1'b0;
        bus.pulse_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_move(input int steps, input bit d, input int ps, input int pm,
                              input int dc);
        bus.cmd_steps        = 16'(steps);
        bus.cmd_dir          = d;
        bus.cfg_period_start = 16'(ps);
        bus.cfg_period_min   = 16'(pm);
        bus.cfg_ramp_dec     = 16'(dc);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_period", 32'(bus.period), 32'd0);
        check_eq("rst_remaining", 32'(bus.remaining), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_drv", 32'(bus.drv_en_SM), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_dir", 32'(bus.dir), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_a[10];
        exp_a = '{90, 80, 70, 60, 60, 60, 70, 80, 90, 100};

        rst_n = 1'b0;
        bus.cmd_start = 1'b0; bus.cmd_stop = 1'b0; bus.cmd_abort = 1'b0;
        bus.pulse_tick = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_steps = '0;
        bus.cfg_period_start = 16'd100; bus.cfg_period_min = 16'd60; bus.cfg_ramp_dec = 16'd10;
        model_reset();
        m_hold = 0;
        repeat (2) @(posedge clk);
        #1;
        cur_test = "reset";
        check_reset_outputs();

        // Release: a start on the first edge afterwards must be lost
        @(negedge clk);
        rst_n = 1'b1;
        m_hold = 1;
        cur_test = "sync";
        bus.cmd_steps = 16'd3;
        bus.cmd_dir   = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);  // tick in IDLE ignored
        idle(1);

        // Full trapezoid with cruise
        cur_test = "A";
        start_move(10, 1'b1, 100, 60, 10);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            check_eq("tbl_period", 32'(bus.period), exp_a[i]);
            check_eq("tbl_rem", 32'(bus.remaining), 32'(9 - i));
            if (i < 9) idle(7);
        end
        check_eq("final_done", 32'(bus.done), 32'd1);
        idle(2);

        // Short move: decel before reaching cruise period
        cur_test = "B";
        start_move(5, 1'b0, 100, 10, 10);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            check_eq("no_cruise", 32'(bus.period == 16'd10), 32'd0);
            if (i < 4) idle(7);
        end
        check_eq("final_done", 32'(bus.done), 32'd1);
        idle(2);

        // Zero-length move
        cur_test = "C";
        start_move(0, 1'b1, 100, 60, 10);
        check_eq("zero_busy", 32'(bus.busy), 32'd1);
        check_eq("zero_done", 32'(bus.done), 32'd1);
        check_eq("zero_drv", 32'(bus.drv_en_SM), 32'd0);
        idle(2);

        // Soft stop from cruise, with an ignored restart mid-move
        cur_test = "D";
        start_move(60, 1'b1, 100, 60, 10);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 2) begin
                bus.cmd_steps = 16'd7;
                bus.cmd_dir   = 1'b0;
                cycle(1'b1, 1'b0, 1'b0, 1'b0);
            end else begin
                idle(1);
            end
        end
        check_eq("pre_stop_rem", 32'(bus.remaining), 32'd50);
        check_eq("busy_dir", 32'(bus.dir), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("stop_rem", 32'(bus.remaining), 32'd4);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end
        check_eq("stop_done", 32'(bus.done), 32'd1);
        check_eq("stop_period", 32'(bus.period), 32'd100);
        idle(2);

        // Abort beats a coincident stop and tick
        cur_test = "E";
        start_move(60, 1'b0, 100, 60, 10);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            idle(1);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_drv", 32'(bus.drv_en_SM), 32'd0);
        check_eq("abort_done", 32'(bus.done), 32'd0);
        idle(3);

        // Stop coinciding with a tick; later stop in DECEL ignored
        cur_test = "F";
        start_move(20, 1'b1, 100, 60, 10);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("stop_tick_rem", 32'(bus.remaining), 32'd2);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("stop_tick_done", 32'(bus.done), 32'd1);
        idle(2);

        // Asynchronous reset mid-ACCEL
        cur_test = "G";
        start_move(20, 1'b1, 100, 60, 10);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        m_hold = 1;
        bus.cmd_steps = 16'd5;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
